// File: rtl/cfg_word_tx_pkg.sv
// Shared types and helpers for the change-detect word transmitter.
// State encoding, commit-counter width and timer width sizing.
package cfg_word_tx_pkg;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int UPDATE_CNT_W = 16;

   // The shared timer must reach RST_DELAY-1, HOLD_CYCLES and REFRESH_PERIOD-1.
   function automatic int cnt_w(input int rst_delay,
                                input int hold_cycles,
                                input int refresh_period);
      int m;
      m = rst_delay;
      if (hold_cycles + 1 > m) m = hold_cycles + 1;
      if (refresh_period > m) m = refresh_period;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/cfg_tx_timer.sv
// Loadable up-counter with terminal-count compare and synchronous clear.
// Priority: reset, clear, load, enable.
module cfg_tx_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] tc_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/cfg_word_tx.sv
// Transmit side of the N-bit change-detect interface: commits staged words with a bvalid hold.
// Optional periodic refresh strobes are built when CFG_WORD_TX_REFRESH_EN is defined.
module cfg_word_tx
   import cfg_word_tx_pkg::*;
#(
   parameter int N              = 8,
   parameter int RST_DELAY      = 100,
   parameter int HOLD_CYCLES    = 4,
   parameter int REFRESH_PERIOD = 1024
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic                    wr_en,
   input  logic [N-1:0]            wr_data,
   output logic                    busy,
   output logic [N-1:0]            dout,
   output logic                    bvalid,
   output logic [UPDATE_CNT_W-1:0] update_count
);

   localparam int CW = cnt_w(RST_DELAY, HOLD_CYCLES, REFRESH_PERIOD);
   localparam logic [CW-1:0] INIT_TC = CW'(RST_DELAY - 1);
   localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t state, state_nx;

   logic [N-1:0]            stage, stage_nx;
   logic                    pending, pending_nx, pend_base;
   logic [N-1:0]            dout_nx;
   logic                    bvalid_nx;
   logic [UPDATE_CNT_W-1:0] upd_nx;

   logic          t_clr, t_load, t_en, t_tc;
   logic [CW-1:0] t_tc_val;

   assign t_tc_val = (state == INIT) ? INIT_TC : HOLD_TC;

   cfg_tx_timer #(.W(CW)) u_phase_timer (
      .clk      (clk),
      .nreset   (nreset),
      .clr      (t_clr),
      .load     (t_load),
      .load_val (ONE),
      .en       (t_en),
      .tc_val   (t_tc_val),
      .tc       (t_tc)
   );

`ifdef CFG_WORD_TX_REFRESH_EN
   localparam logic [CW-1:0] REF_TC =
      (REFRESH_PERIOD == 0) ? '0 : CW'(REFRESH_PERIOD - 1);

   logic r_clr, r_en, r_tc;

   cfg_tx_timer #(.W(CW)) u_refresh_timer (
      .clk      (clk),
      .nreset   (nreset),
      .clr      (r_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (r_en),
      .tc_val   (REF_TC),
      .tc       (r_tc)
   );
`endif

   always_comb begin
      state_nx  = state;
      dout_nx   = dout;
      bvalid_nx = 1'b0;
      upd_nx    = update_count;
      pend_base = pending;
      t_clr     = 1'b0;
      t_load    = 1'b0;
      t_en      = 1'b0;
`ifdef CFG_WORD_TX_REFRESH_EN
      r_clr     = 1'b1;
      r_en      = 1'b0;
`endif
      unique case (state)
         INIT: begin
            if (t_tc) begin
               state_nx = IDLE;
               t_clr    = 1'b1;
            end else begin
               t_en = 1'b1;
            end
         end
         IDLE: begin
            if (pending) begin
               dout_nx   = stage;
               bvalid_nx = 1'b1;
               pend_base = 1'b0;
               upd_nx    = update_count + 1'b1;
               t_load    = 1'b1;
               state_nx  = HOLD;
            end else begin
`ifdef CFG_WORD_TX_REFRESH_EN
               if (REFRESH_PERIOD != 0) begin
                  if (r_tc) begin
                     bvalid_nx = 1'b1;
                  end else begin
                     r_clr = 1'b0;
                     r_en  = 1'b1;
                  end
               end
`endif
            end
         end
         HOLD: begin
            if (t_tc) begin
               state_nx = IDLE;
               t_clr    = 1'b1;
            end else begin
               bvalid_nx = 1'b1;
               t_en      = 1'b1;
            end
         end
         default: begin
            state_nx = INIT;
            t_clr    = 1'b1;
         end
      endcase

      // Pending is judged against the word dout will hold after this edge.
      stage_nx   = wr_en ? wr_data : stage;
      pending_nx = wr_en ? (wr_data != dout_nx) : pend_base;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state        <= INIT;
         busy         <= 1'b1;
         dout         <= '0;
         bvalid       <= 1'b0;
         update_count <= '0;
         stage        <= '0;
         pending      <= 1'b0;
      end else begin
         state        <= state_nx;
         busy         <= (state_nx != IDLE);
         dout         <= dout_nx;
         bvalid       <= bvalid_nx;
         update_count <= upd_nx;
         stage        <= stage_nx;
         pending      <= pending_nx;
      end
   end

endmodule
